// File: rtl/pipe_stage_fifo.sv
// Valid/ready pipeline stage holding up to DEPTH payloads, with flush-on-redirect
// and optional enqueue-while-full when the head leaves in the same cycle.
module pipe_stage_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 2,
   parameter bit READY_PASS = 1'b1,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   // Handshake: a transfer happens on a rising edge exactly when valid && ready
   // are both high on that side; valid never waits on ready. in_ready ignores
   // flush_i, but any enqueue offered while flushing is dropped.

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rp;
   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] rp_next;
   logic [PTR_W-1:0] wp_next;
   logic [CNT_W-1:0] count_next;
   logic             enq;
   logic             deq;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign out_valid = !empty && !flush_i;
   assign out_data  = out_valid ? mem[rp] : '0;
   assign in_ready  = !full || (READY_PASS && out_ready && out_valid);

   assign enq = in_valid && in_ready && !flush_i;
   assign deq = out_valid && out_ready;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   always_comb begin
      rp_next    = rp;
      wp_next    = wp;
      count_next = count;
      if (deq) begin
         rp_next = (rp == LAST_PTR) ? '0 : rp + PTR_W'(1);
      end
      if (enq) begin
         wp_next = (wp == LAST_PTR) ? '0 : wp + PTR_W'(1);
      end
      case ({enq, deq})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else begin
         rp    <= rp_next;
         wp    <= wp_next;
         count <= count_next;
      end
   end

   // Storage is never cleared; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         mem[wp] <= in_data;
      end
   end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised successor to the single-entry ID/EXE-style pipeline register. It is a valid/ready pipeline stage holding up to DEPTH in-flight payloads of WIDTH bits, with flush-on-redirect and optional full-throughput enqueue-while-full. It sits between any two pipeline stages (IDU→EXEU, EXEU→LSU, …) and decouples upstream from downstream stalls without losing throughput.

## Interface
- WIDTH, 32: payload width in bits; ≥1.
- DEPTH, 2: number of entries; ≥1, any integer (not restricted to powers of two).
- READY_PASS, 1: 1 = `in_ready` also asserts when full and a dequeue happens this cycle; 0 = `in_ready` = !full.
- CNT_W, $clog2(DEPTH+1): width of `count`; derived, not overridden.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush_i  in  1  redirect; discards all entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid and not being flushed.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  head payload; all-zero when out_valid=0.
- count  out  CNT_W  occupied entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

## Operation
- Storage: DEPTH×WIDTH register array, read pointer `rp`, write pointer `wp`, occupancy `count`. Pointers increment modulo DEPTH (wrap from DEPTH-1 to 0).
- Enqueue fires when in_valid && in_ready && !flush_i: write in_data at wp, and wp advances.
- Dequeue fires when out_valid && out_ready: rp advances.
- count next = count + enq − deq. A simultaneous enqueue and dequeue leaves count unchanged.
- out_valid = !empty && !flush_i (combinational flush gating).
- out_data = mem[rp] when out_valid, else 0.
- in_ready = !full || (READY_PASS && out_ready && out_valid). in_ready does not depend on flush_i, but an enqueue during flush is discarded.
- Flush (priority over everything but reset): next cycle count=0, rp=wp=0. Array contents need not be cleared.
- Reset: count=0, rp=wp=0. Outputs after reset: out_valid=0, out_data=0, in_ready=1, count=0, full=0, empty=1.
- No combinational in→out bypass. A payload is never visible at the output in the cycle it is enqueued.

## Timing
- Latency: a payload enqueued at edge N is presented at the output from cycle N+1 if the stage was empty.
- Throughput: 1 transfer/cycle sustained when DEPTH≥2, or when DEPTH=1 with READY_PASS=1.
- READY_PASS=0, DEPTH=1: half throughput. This matches the legacy behaviour.
- Empty with in_valid && out_ready in the same cycle: the enqueue fires and no dequeue occurs, because out_valid=0.
- Full with READY_PASS=1 and out_ready=1: dequeue and enqueue happen on the same edge, wp and rp both advance, and count stays DEPTH.
- Full with out_ready=0: in_ready=0, and upstream holds its data.
- flush_i asserted: out_valid drops in the same cycle; empty=1 from the next cycle. flush_i held for several cycles keeps the stage empty.
- Reset asserted mid-transfer: state returns to the reset values on the next edge, and any handshake in that cycle is ignored.
- Downstream must not rely on out_data while out_valid=0.

## Test plan
- Reset then idle:
  - Assert reset for 2 cycles.
  - Required: out_valid=0, out_data=0, in_ready=1, count=0, empty=1, full=0.
- Fill and drain, DEPTH=4:
  - Enqueue 0x11, 0x22, 0x33, 0x44 with out_ready=0.
  - Required: count=4, full=1, in_ready=0.
  - Then set out_ready=1. Required: outputs 0x11..0x44 in order on 4 consecutive cycles, then empty=1.
- Wrap-around and streaming, DEPTH=3, READY_PASS=1:
  - Stream 10 payloads 0..9 with in_valid=out_ready=1 continuously.
  - Required: outputs 0..9 in order, one per cycle, with 1-cycle latency; count never exceeds 1.
- Full pass-through, DEPTH=2, READY_PASS=1:
  - Fill to full, then assert in_valid=out_ready=1 with 0xAA.
  - Required: in_ready=1, head dequeued, 0xAA accepted, count stays 2.
  - Repeat with READY_PASS=0. Required: in_ready=0.
- Flush mid-stream:
  - With count=3, assert flush_i and in_valid=1 with 0x55.
  - Required: out_valid=0 and out_data=0 in the same cycle; next cycle count=0 and 0x55 is not stored.
  - Following enqueue 0x66. Required: appears at the output one cycle later.
- Randomised backpressure:
  - Drive random in_valid/out_ready for 1000 cycles against a scoreboard.
  - Required: no loss, no duplication, order preserved; count matches the scoreboard occupancy every cycle.
